// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between instruction and data requesters
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          owner,
  output logic          timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, stateNext;
  logic [15:0] tmoCnt;
  logic grantValid, grantSide, timeoutHit, finish;
  always_comb begin
    grantValid = (state == IDLE) && (i_req || d_req);
    grantSide  = (i_req && d_req) ? ~owner : d_req;
    timeoutHit = (state == BUSY) && !mem_ready && (tmoCnt == 16'(TMO - 1));
    finish     = (state == BUSY) && (mem_ready || timeoutHit);
    stateNext  = (state == IDLE) ? (grantValid ? BUSY : IDLE) :
                 (state == BUSY) ? (finish ? RESP : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      busy        <= 1'b0;
      owner       <= 1'b1;
      timeout_err <= 1'b0;
      tmoCnt      <= '0;
    end else begin
      busy        <= stateNext != IDLE;
      mem_req     <= stateNext == BUSY;
      i_done      <= finish && !owner;
      d_done      <= finish && owner;
      timeout_err <= timeout_err || timeoutHit;
      if (grantValid) begin
        owner     <= grantSide;
        mem_we    <= grantSide && d_we;
        mem_addr  <= grantSide ? d_addr : i_addr;
        mem_wdata <= grantSide ? d_wdata : '0;
        tmoCnt    <= '0;
      end else if (state == BUSY && !mem_ready) begin
        tmoCnt <= tmoCnt + 16'd1;
      end
      // a timed-out access returns zero data so stale words never look valid
      if (finish && owner)  d_rdata <= mem_ready ? mem_rdata : '0;
      if (finish && !owner) i_rdata <= mem_ready ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with an auto-responding memory model
module tb_mem_port_arbiter;
  localparam int TMO = 64;
  typedef struct packed {logic side; logic [31:0] data;} exp_t;
  logic clk = 0, rst = 0;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic i_done, d_done, mem_req, mem_we, mem_ready, busy, owner, timeout_err;
  logic rReady = 0, mReady = 0, autoResp = 1;
  int lat = 0, waitCnt = 0;
  int checks = 0, passed = 0;
  exp_t sb[$];

  assign mem_ready = rReady | mReady;
  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  function automatic logic [31:0] memVal(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000) + 32'd7;
  endfunction

  // memory model: answers after lat BUSY cycles with data derived from the address
  always @(negedge clk) begin
    if (autoResp && mem_req && !rReady && waitCnt >= lat) begin
      rReady = 1;
      mem_rdata = memVal(mem_addr);
    end else begin
      rReady = 0;
      waitCnt = mem_req ? waitCnt + 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (rst && (i_done || d_done)) begin
      exp_t e;
      logic [31:0] rd;
      checks++;
      rd = d_done ? d_rdata : i_rdata;
      if (i_done && d_done) $display("FAIL done_both: i_done=1 d_done=1, required one only");
      else if (sb.size() == 0) $display("FAIL unexpected_done: side=%0d data=%h, required none", d_done, rd);
      else begin
        e = sb.pop_front();
        if (d_done !== e.side || rd !== e.data)
          $display("FAIL completion: side=%0d data=%h, required side=%0d data=%h", d_done, rd, e.side, e.data);
        else passed++;
      end
    end
  end

  task automatic waitDones(input int n);
    int got = 0;
    for (int k = 0; k < 500 && got < n; k++) begin
      @(negedge clk);
      if (i_done) begin i_req = 0; got++; end
      if (d_done) begin d_req = 0; got++; end
    end
    checks++;
    if (got != n) $display("FAIL done_count: got %0d, required %0d", got, n); else passed++;
    @(negedge clk);
    checks++;
    if ({i_done, d_done} !== 2'b00) $display("FAIL done_width: i_done=%b d_done=%b, required 0 0", i_done, d_done);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, i_done, d_done, busy, timeout_err} !== 6'b0)
      $display("FAIL reset_ctrl: req/we/idone/ddone/busy/terr=%b, required 000000",
               {mem_req, mem_we, i_done, d_done, busy, timeout_err});
    else passed++;
    checks++;
    if (mem_addr !== 0 || mem_wdata !== 0) $display("FAIL reset_mem: addr=%h wdata=%h, required 0 0", mem_addr, mem_wdata);
    else passed++;
    checks++;
    if (i_rdata !== 0 || d_rdata !== 0) $display("FAIL reset_rdata: i=%h d=%h, required 0 0", i_rdata, d_rdata);
    else passed++;
    checks++;
    if (owner !== 1'b1) $display("FAIL reset_owner: owner=%b, required 1", owner); else passed++;
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_ifetch;
    autoResp = 1; lat = 0;
    i_req = 1; i_addr = 32'h100;
    sb.push_back({1'b0, 32'hDEADBEEF});
    @(negedge clk);
    checks++;
    if (mem_req !== 1 || mem_addr !== 32'h100 || mem_we !== 0 || busy !== 1)
      $display("FAIL ifetch_busy: req=%b addr=%h we=%b busy=%b, required 1 100 0 1", mem_req, mem_addr, mem_we, busy);
    else passed++;
    @(negedge clk);
    checks++;
    if (i_done !== 1 || d_done !== 0) $display("FAIL ifetch_latency: i_done=%b d_done=%b, required 1 0", i_done, d_done);
    else passed++;
    i_req = 0;
    @(negedge clk);
    checks++;
    if (i_done !== 0 || busy !== 0 || mem_req !== 0)
      $display("FAIL ifetch_idle: i_done=%b busy=%b req=%b, required 0 0 0", i_done, busy, mem_req);
    else passed++;
  endtask

  task automatic test_write;
    int beats = 0, bad = 0;
    logic seen = 0;
    autoResp = 1; lat = 3;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h12345678;
    sb.push_back({1'b1, memVal(32'h2000)});
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (d_done) begin seen = 1; break; end
      if (mem_req) begin
        beats++;
        if (mem_we !== 1 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h2000) bad++;
        d_addr = 32'h3000; d_wdata = 32'hFFFF0000;
      end
    end
    d_req = 0; d_we = 0;
    checks++;
    if (!seen) $display("FAIL write_done: no d_done within budget, required one"); else passed++;
    checks++;
    if (bad != 0) $display("FAIL write_hold: %0d unstable BUSY cycles, required 0", bad); else passed++;
    checks++;
    if (beats != 4) $display("FAIL write_beats: %0d BUSY cycles, required 4", beats); else passed++;
    checks++;
    if (i_rdata !== 32'hDEADBEEF) $display("FAIL nonowner_hold: i_rdata=%h, required deadbeef", i_rdata); else passed++;
    @(negedge clk);
    checks++;
    if (d_done !== 0 || mem_addr !== 32'h2000) $display("FAIL write_after: d_done=%b addr=%h, required 0 2000", d_done, mem_addr);
    else passed++;
    lat = 0;
  endtask

  task automatic test_roundrobin;
    rst = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      i_req = 1; d_req = 1;
      i_addr = 32'h40 + 32'(r); d_addr = 32'h80 + 32'(r);
      sb.push_back({1'b0, memVal(32'h40 + 32'(r))});
      sb.push_back({1'b1, memVal(32'h80 + 32'(r))});
      waitDones(2);
    end
  endtask

  task automatic test_timeout_edge;
    int beats = 0;
    autoResp = 1; lat = TMO - 1;
    d_req = 1; d_addr = 32'h500;
    sb.push_back({1'b1, memVal(32'h500)});
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (d_done) break;
      if (mem_req) beats++;
    end
    d_req = 0;
    checks++;
    if (beats != TMO || timeout_err !== 0)
      $display("FAIL ready_precedence: beats=%0d terr=%b, required %0d 0", beats, timeout_err, TMO);
    else passed++;
    @(negedge clk);
    lat = 0;
  endtask

  task automatic test_timeout;
    int beats = 0;
    autoResp = 0;
    d_req = 1; d_addr = 32'h300;
    sb.push_back({1'b1, 32'h0});
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (d_done) break;
      if (mem_req) beats++;
    end
    d_req = 0;
    checks++;
    if (beats != TMO) $display("FAIL timeout_beats: mem_req high %0d cycles, required %0d", beats, TMO); else passed++;
    checks++;
    if (timeout_err !== 1) $display("FAIL timeout_flag: terr=%b, required 1", timeout_err); else passed++;
    @(negedge clk);
    autoResp = 1;
    i_req = 1; i_addr = 32'h100;
    sb.push_back({1'b0, 32'hDEADBEEF});
    waitDones(1);
    checks++;
    if (timeout_err !== 1) $display("FAIL timeout_sticky: terr=%b, required 1", timeout_err); else passed++;
  endtask

  task automatic test_idle_ready;
    mReady = 1;
    @(negedge clk);
    mReady = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, mem_req, i_done, d_done} !== 4'b0)
      $display("FAIL idle_ready: busy/req/idone/ddone=%b, required 0000", {busy, mem_req, i_done, d_done});
    else passed++;
  endtask

  task automatic test_reset_busy;
    logic seen = 0;
    autoResp = 0;
    d_req = 1; d_addr = 32'h700;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_req) begin seen = 1; break; end
    end
    checks++;
    if (!seen) $display("FAIL rb_start: mem_req never rose, required 1"); else passed++;
    @(posedge clk);
    #2 rst = 0;
    #1;
    checks++;
    if ({mem_req, busy, d_done, timeout_err} !== 4'b0)
      $display("FAIL reset_async: req/busy/ddone/terr=%b, required 0000", {mem_req, busy, d_done, timeout_err});
    else passed++;
    d_req = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    autoResp = 1;
    @(negedge clk);
    i_req = 1; d_req = 1; i_addr = 32'h900; d_addr = 32'hA00;
    sb.push_back({1'b0, memVal(32'h900)});
    sb.push_back({1'b1, memVal(32'hA00)});
    waitDones(2);
  endtask

  initial begin
    test_reset;
    test_ifetch;
    test_write;
    test_roundrobin;
    test_timeout_edge;
    test_timeout;
    test_idle_ready;
    test_reset_busy;
    checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
